traffic_state_sequencer: RTL

//   Timed FSM that generates the 2-bit traffic-light state code consumed by the

---
 rtl/traffic_pkg.sv | 31 +++
 rtl/phase_timer.sv | 39 +++
 rtl/traffic_state_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared traffic-light state encodings and phase ordering helper.
// Also imported by the lamp decoder so codes never diverge.
package traffic_pkg;

  localparam logic [1:0] ST_RED    = 2'b00;
  localparam logic [1:0] ST_GREEN  = 2'b01;
  localparam logic [1:0] ST_YELLOW = 2'b10;
  localparam logic [1:0] ST_FAULT  = 2'b11;

  typedef enum logic [1:0] {
    S_RED    = ST_RED,
    S_GREEN  = ST_GREEN,
    S_YELLOW = ST_YELLOW,
    S_FAULT  = ST_FAULT
  } tl_state_e;

  // Normal rotation; FAULT always recovers through RED.
  function automatic tl_state_e next_phase(
    input tl_state_e s
  );
    tl_state_e n;
    unique case (s)
      S_RED:    n = S_GREEN;
      S_GREEN:  n = S_YELLOW;
      S_YELLOW: n = S_RED;
      default:  n = S_RED;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter holding strobes left in the current phase.
// Load wins over decrement; the count never wraps below zero.
module phase_timer #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_state_sequencer.sv
// Timed RED/GREEN/YELLOW sequencer with pedestrian shortening
// and a forced FAULT code; all outputs registered.
module traffic_state_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned RED_TICKS       = 8,
  parameter int unsigned GREEN_TICKS     = 12,
  parameter int unsigned YELLOW_TICKS    = 3,
  parameter int unsigned MIN_GREEN_TICKS = 4,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             enable,
  input  logic             ped_req,
  input  logic             fault_in,
  input  logic             fault_clr,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] remaining,
  output logic             phase_done,
  output logic             ped_ack
);

  localparam logic [CNT_W-1:0] RED_LD = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] GRN_LD = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YEL_LD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_LD = CNT_W'(MIN_GREEN_TICKS - 1);

  function automatic logic [CNT_W-1:0] reload_val(
    input tl_state_e s
  );
    logic [CNT_W-1:0] v;
    unique case (s)
      S_RED:    v = RED_LD;
      S_GREEN:  v = GRN_LD;
      S_YELLOW: v = YEL_LD;
      default:  v = '0;
    endcase
    return v;
  endfunction

  tl_state_e        state_q, state_d;
  logic [CNT_W-1:0] ge_q, ge_d;
  logic             latch_q, latch_d;
  logic             pd_q, pd_d;
  logic             ack_q, ack_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;
  logic [CNT_W-1:0] tmr_cnt;

  logic strobe;
  logic early;
  logic clr_latch;

  assign strobe = enable & tick_en;
  assign early  = (state_q == S_GREEN) && latch_q
                  && (ge_q >= MIN_LD);

  always_comb begin
    state_d   = state_q;
    ge_d      = ge_q;
    pd_d      = 1'b0;
    ack_d     = 1'b0;
    clr_latch = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = RED_LD;
    tmr_dec   = 1'b0;

    if (fault_in) begin
      state_d  = S_FAULT;
      tmr_load = 1'b1;
      tmr_val  = '0;
      pd_d     = (state_q != S_FAULT);
    end else if (state_q == S_FAULT) begin
      if (fault_clr) begin
        state_d  = S_RED;
        tmr_load = 1'b1;
        tmr_val  = RED_LD;
        ge_d     = '0;
        pd_d     = 1'b1;
      end
    end else if (strobe) begin
      if (early || tmr_zero) begin
        state_d  = early ? S_YELLOW
                         : next_phase(state_q);
        tmr_load = 1'b1;
        tmr_val  = reload_val(state_d);
        ge_d     = '0;
        pd_d     = 1'b1;
        // Only the YELLOW->RED edge acknowledges a served request.
        if (state_q == S_YELLOW) begin
          ack_d     = latch_q;
          clr_latch = latch_q;
        end
      end else begin
        tmr_dec = 1'b1;
        if (state_q == S_GREEN) begin
          ge_d = ge_q + 1'b1;
        end
      end
    end

    // A request landing on the ack edge is kept for the next GREEN.
    latch_d = ped_req | (latch_q & ~clr_latch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RED;
      ge_q    <= '0;
      latch_q <= 1'b0;
      pd_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ge_q    <= ge_d;
      latch_q <= latch_d;
      pd_q    <= pd_d;
      ack_q   <= ack_d;
    end
  end

  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(RED_TICKS - 1)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .cnt_o     (tmr_cnt),
    .zero_o    (tmr_zero)
  );

  assign state      = state_q;
  assign remaining  = tmr_cnt;
  assign phase_done = pd_q;
  assign ped_ack    = ack_q;

endmodule
